// File: rtl/rv32i_ctrl_pkg.sv
// Shared RV32I control-path types: fetch FSM states, IF/ID payload, bubble encoding.
// Pure declarations, no latency; no handshake of its own.
// Fetch and decode stages import it so both sides agree on the IF/ID layout.
package rv32i_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > stall-hold > load > bubble priority.
// Latency: one cycle from load_vld to q.
// Backpressure: holds contents while stall is high and a real instruction is held.
module if_id_reg
  import rv32i_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv32i_ctrl_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  logic   load_vld,
  input  if_id_t load_dat,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr    <= NOP_INSTR;
      q.pc       <= 32'd0;
      q.pc_plus4 <= 32'd0;
      q.valid    <= 1'b0;
    end else if (flush) begin
      // PC fields are left alone so a flushed slot still reports where it was.
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (stall && q.valid) begin
      q <= q;
    end else if (load_vld) begin
      q <= load_dat;
    end else begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem port, one-word skid buffer, IF/ID register.
// Latency: gnt to valid_d is rvalid latency + 1 cycle; peak one instruction per 2 cycles.
// Backpressure: stall_d parks a returned word in the skid buffer; no new request until it drains.
module fetch_stage
  import rv32i_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32i_ctrl_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [6:0]  opcode_d,
  output logic [2:0]  funct3_d,
  output logic        funct7_5_d
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic         drop_q;
  logic [31:0]  buf_dat_q;
  logic [31:0]  buf_pc_q;
  logic         buf_vld_q;

  logic [31:0]  target;
  logic         req_gnt;
  logic         rsp_take;
  logic         rsp_drop;
  logic         if_id_free;
  logic         rsp_load;
  logic         rsp_park;
  logic         buf_load;
  logic         hold_exit;
  logic         load_vld;
  if_id_t       load_dat;
  if_id_t       if_id_q;

  always_comb begin
    target     = word_align(redirect_target);
    req_gnt    = (state_q == REQ) && imem_gnt;
    rsp_take   = (state_q == WAIT) && imem_rvalid;
    // A redirect arriving with the response kills it just like a pending drop.
    rsp_drop   = rsp_take && (drop_q || redirect);
    if_id_free = !stall_d || !if_id_q.valid;
    rsp_load   = rsp_take && !rsp_drop && if_id_free;
    rsp_park   = rsp_take && !rsp_drop && !if_id_free;
    hold_exit  = (state_q == HOLD) && (redirect || !stall_d);
    buf_load   = (state_q == HOLD) && buf_vld_q && !redirect && !stall_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_gnt) state_d = WAIT;
      WAIT: begin
        if (rsp_drop || rsp_load) begin
          state_d = REQ;
        end else if (rsp_park) begin
          state_d = HOLD;
        end
      end
      HOLD: if (redirect || !stall_d) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= 32'd0;
      drop_q     <= 1'b0;
      buf_dat_q  <= 32'd0;
      buf_pc_q   <= 32'd0;
      buf_vld_q  <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q <= target;
      end else if (req_gnt) begin
        pc_q <= pc_q + 32'd4;
      end

      if (req_gnt && !redirect) begin
        fetch_pc_q <= pc_q;
      end

      // A redirect with a fetch in flight marks its response for discard.
      if (req_gnt && redirect) begin
        drop_q <= 1'b1;
      end else if (rsp_take) begin
        drop_q <= 1'b0;
      end else if ((state_q == WAIT) && redirect) begin
        drop_q <= 1'b1;
      end

      if (rsp_park) begin
        buf_dat_q <= imem_rdata;
        buf_pc_q  <= fetch_pc_q;
        buf_vld_q <= 1'b1;
      end else if (hold_exit) begin
        buf_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    load_vld = rsp_load || buf_load;
    if (rsp_load) begin
      load_dat.instr    = imem_rdata;
      load_dat.pc       = fetch_pc_q;
      load_dat.pc_plus4 = fetch_pc_q + 32'd4;
    end else begin
      load_dat.instr    = buf_dat_q;
      load_dat.pc       = buf_pc_q;
      load_dat.pc_plus4 = buf_pc_q + 32'd4;
    end
    load_dat.valid = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_d),
    .stall    (stall_d),
    .load_vld (load_vld),
    .load_dat (load_dat),
    .q        (if_id_q)
  );

  always_comb begin
    instr_d    = if_id_q.instr;
    pc_d       = if_id_q.pc;
    pc_plus4_d = if_id_q.pc_plus4;
    valid_d    = if_id_q.valid;
    opcode_d   = if_id_q.instr[6:0];
    funct3_d   = if_id_q.instr[14:12];
    funct7_5_d = if_id_q.instr[30];
  end

  a_rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_rvalid && (state_q != WAIT))
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall/skid, redirects, flush, PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        flush_d;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [6:0]  opcode_d;
  logic [2:0]  funct3_d;
  logic        funct7_5_d;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .opcode_d        (opcode_d),
    .funct3_d        (funct3_d),
    .funct7_5_d      (funct7_5_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_gnt        = 1'b1;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'd0;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;

    // Reset values
    tick();
    tick();
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_addr",  imem_addr,      32'h0000_0000);
    chk("rst_instr", instr_d,        32'h0000_0013);
    chk("rst_pc",    pc_d,           32'd0);
    chk("rst_pc4",   pc_plus4_d,     32'd0);
    chk("rst_valid", 32'(valid_d),   32'd0);
    rst_n = 1'b1;

    // First fetch at address 0, single-cycle rvalid
    tick();
    chk("f1_req",  32'(imem_req), 32'd1);
    chk("f1_addr", imem_addr,     32'h0000_0000);
    tick();
    chk("f1_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("f1_instr",  instr_d,        32'h0050_0093);
    chk("f1_pc",     pc_d,           32'h0000_0000);
    chk("f1_pc4",    pc_plus4_d,     32'h0000_0004);
    chk("f1_valid",  32'(valid_d),   32'd1);
    chk("f1_opcode", 32'(opcode_d),  32'h13);
    chk("f1_next",   imem_addr,      32'h0000_0004);

    // Stall held 3 cycles while the response lands in the skid buffer
    stall_d = 1'b1;
    tick();
    chk("st_wait_req", 32'(imem_req), 32'd0);
    chk("st_hold1",    instr_d,       32'h0050_0093);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4020_D1B3;
    tick();
    imem_rvalid = 1'b0;
    chk("st_hold_req", 32'(imem_req), 32'd0);
    chk("st_hold2",    instr_d,       32'h0050_0093);
    tick();
    chk("st_hold3_req", 32'(imem_req), 32'd0);
    chk("st_hold3_vld", 32'(valid_d),  32'd1);
    chk("st_hold3_pc",  pc_d,          32'h0000_0000);
    stall_d = 1'b0;
    tick();
    chk("st_instr",  instr_d,          32'h4020_D1B3);
    chk("st_pc",     pc_d,             32'h0000_0004);
    chk("st_pc4",    pc_plus4_d,       32'h0000_0008);
    chk("st_valid",  32'(valid_d),     32'd1);
    chk("st_opcode", 32'(opcode_d),    32'h33);
    chk("st_funct3", 32'(funct3_d),    32'd5);
    chk("st_f7_5",   32'(funct7_5_d),  32'd1);
    chk("st_req",    32'(imem_req),    32'd1);
    chk("st_addr",   imem_addr,        32'h0000_0008);

    // Redirect to 0x100 while waiting; in-flight word is dropped
    tick();
    chk("rw_req", 32'(imem_req), 32'd0);
    redirect        = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_valid", 32'(valid_d),  32'd0);
    chk("rw_req2",  32'(imem_req), 32'd1);
    chk("rw_addr",  imem_addr,     32'h0000_0100);

    // Redirect coincident with gnt; misaligned target is word-aligned
    redirect        = 1'b1;
    redirect_target = 32'h0000_0207;
    tick();
    redirect = 1'b0;
    chk("rg_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    chk("rg_valid", 32'(valid_d),  32'd0);
    chk("rg_instr", instr_d,       32'h0000_0013);
    chk("rg_req2",  32'(imem_req), 32'd1);
    chk("rg_addr",  imem_addr,     32'h0000_0204);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("rg_instr2", instr_d,      32'h0010_0093);
    chk("rg_pc",     pc_d,         32'h0000_0204);
    chk("rg_pc4",    pc_plus4_d,   32'h0000_0208);
    chk("rg_valid2", 32'(valid_d), 32'd1);
    chk("rg_next",   imem_addr,    32'h0000_0208);

    // Flush and stall together: flush wins, pc fields kept
    flush_d = 1'b1;
    stall_d = 1'b1;
    tick();
    flush_d = 1'b0;
    stall_d = 1'b0;
    chk("fl_valid",  32'(valid_d),  32'd0);
    chk("fl_instr",  instr_d,       32'h0000_0013);
    chk("fl_pc",     pc_d,          32'h0000_0204);
    chk("fl_opcode", 32'(opcode_d), 32'h13);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("fl_after_valid", 32'(valid_d), 32'd1);
    chk("fl_after_pc",    pc_d,         32'h0000_0208);

    // Redirect without gnt, then PC wrap at the top of the address space
    imem_gnt        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    chk("wr_req",  32'(imem_req), 32'd1);
    chk("wr_addr", imem_addr,     32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0030_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("wr_pc",    pc_d,         32'hFFFF_FFFC);
    chk("wr_pc4",   pc_plus4_d,   32'h0000_0000);
    chk("wr_valid", 32'(valid_d), 32'd1);
    chk("wr_next",  imem_addr,    32'h0000_0000);
    chk("wr_req2",  32'(imem_req), 32'd1);

    // Asynchronous reset mid-operation takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   32'(imem_req), 32'd0);
    chk("ar_addr",  imem_addr,     32'h0000_0000);
    chk("ar_valid", 32'(valid_d),  32'd0);
    chk("ar_instr", instr_d,       32'h0000_0013);
    chk("ar_pc",    pc_d,          32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
